round_key_bank: RTL and testbench

//   Parametrised multi-bank round-key store for the Kuznechik core. Key expander streams

---
 rtl/round_key_bank.sv | 173 +++++++++++++++++
 tb/tb_round_key_bank.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/round_key_bank.sv
// round_key_bank: multi-bank round-key store for the Kuznechik core.
// The key expander streams DEPTH round keys into a chosen bank through a valid/ready
// handshake. The cipher datapath reads keys with one cycle of latency. The store tracks
// which banks are fully loaded, flags bad reads, and supports a zeroize sweep.
//
// Ports:
//   i_clk, i_rst      clock (rising edge), asynchronous active-high reset
//   i_wr_start        begin loading bank i_wr_bank (only honoured in IDLE)
//   i_wr_valid/o_wr_ready/i_wr_data   key stream, keys written in order K1..K_DEPTH
//   i_zeroize         erase every bank
//   i_rd_en/i_rd_bank/i_rd_addr       read request
//   o_rd_data/o_rd_valid/o_rd_err     read response, one cycle after the request
//   o_bank_ready      bit b set when bank b is fully loaded and readable
//   o_busy            FSM is not idle
module round_key_bank #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned BANKS = 2,
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned BW = (BANKS > 1) ? $clog2(BANKS) : 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_wr_start,
  input  logic [BW-1:0]    i_wr_bank,
  input  logic             i_wr_valid,
  input  logic [WIDTH-1:0] i_wr_data,
  output logic             o_wr_ready,
  input  logic             i_zeroize,
  input  logic             i_rd_en,
  input  logic [BW-1:0]    i_rd_bank,
  input  logic [AW-1:0]    i_rd_addr,
  output logic [WIDTH-1:0] o_rd_data,
  output logic             o_rd_valid,
  output logic             o_rd_err,
  output logic [BANKS-1:0] o_bank_ready,
  output logic             o_busy
);

  localparam int unsigned NENT = BANKS * DEPTH;
  localparam int unsigned LW   = (NENT > 1) ? $clog2(NENT) : 1;

  typedef enum logic [1:0] {StIdle, StLoad, StZero} state_e;

  state_e           r_state;
  logic [BW-1:0]    r_bank;
  logic [AW-1:0]    r_ptr;
  logic [LW-1:0]    r_zidx;
  logic [BANKS-1:0] r_bank_ready;
  logic [WIDTH-1:0] r_rd_data;
  logic             r_rd_valid;
  logic             r_rd_err;

  // Key storage, bank-major linear index. Deliberately not reset: contents are only
  // visible through banks whose ready bit has been set by a completed load.
  logic [WIDTH-1:0] r_mem [NENT];

  logic             w_wr_bank_ok;
  logic             w_wr_fire;
  logic [LW-1:0]    w_wr_lin;
  logic             w_rd_ok;
  logic [LW-1:0]    w_rd_lin;
  logic [WIDTH-1:0] w_rd_word;

  assign o_wr_ready   = (r_state == StLoad);
  assign o_busy       = (r_state != StIdle);
  assign o_bank_ready = r_bank_ready;
  assign o_rd_data    = r_rd_data;
  assign o_rd_valid   = r_rd_valid;
  assign o_rd_err     = r_rd_err;

  assign w_wr_bank_ok = (32'(i_wr_bank) < BANKS);
  // A zeroize arriving in LOAD aborts the load; the beat offered that cycle is dropped.
  assign w_wr_fire    = (r_state == StLoad) && i_wr_valid && !i_zeroize;
  assign w_wr_lin     = LW'(r_bank) * LW'(DEPTH) + LW'(r_ptr);

  always_comb begin
    w_rd_ok   = 1'b0;
    w_rd_lin  = '0;
    w_rd_word = '0;
    if ((32'(i_rd_bank) < BANKS) && (32'(i_rd_addr) < DEPTH)) begin
      w_rd_ok  = r_bank_ready[i_rd_bank];
      w_rd_lin = LW'(i_rd_bank) * LW'(DEPTH) + LW'(i_rd_addr);
      // Write-first on a same-entry collision.
      if (w_wr_fire && (w_wr_lin == w_rd_lin)) begin
        w_rd_word = i_wr_data;
      end else begin
        w_rd_word = r_mem[w_rd_lin];
      end
    end
  end

  // Control FSM and per-bank completion tracking.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state      <= StIdle;
      r_bank       <= '0;
      r_ptr        <= '0;
      r_zidx       <= '0;
      r_bank_ready <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (i_zeroize) begin
            r_state      <= StZero;
            r_zidx       <= '0;
            r_bank_ready <= '0;
          end else if (i_wr_start && w_wr_bank_ok) begin
            r_state                 <= StLoad;
            r_bank                  <= i_wr_bank;
            r_ptr                   <= '0;
            r_bank_ready[i_wr_bank] <= 1'b0;
          end
        end
        StLoad: begin
          if (i_zeroize) begin
            r_state      <= StZero;
            r_ptr        <= '0;
            r_zidx       <= '0;
            r_bank_ready <= '0;
          end else if (i_wr_valid) begin
            if (r_ptr == AW'(DEPTH - 1)) begin
              r_ptr                <= '0;
              r_bank_ready[r_bank] <= 1'b1;
              r_state              <= StIdle;
            end else begin
              r_ptr <= r_ptr + AW'(1);
            end
          end
        end
        StZero: begin
          if (r_zidx == LW'(NENT - 1)) begin
            r_zidx  <= '0;
            r_state <= StIdle;
          end else begin
            r_zidx <= r_zidx + LW'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Storage writes: load beats, or one zero per cycle during the sweep.
  always_ff @(posedge i_clk) begin
    if (w_wr_fire) begin
      r_mem[w_wr_lin] <= i_wr_data;
    end else if (r_state == StZero) begin
      r_mem[r_zidx] <= '0;
    end
  end

  // Read port: independent of the FSM, one cycle latency, data held when idle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
      r_rd_err   <= 1'b0;
    end else begin
      r_rd_valid <= i_rd_en;
      if (i_rd_en) begin
        if (w_rd_ok) begin
          r_rd_err  <= 1'b0;
          r_rd_data <= w_rd_word;
        end else begin
          r_rd_err  <= 1'b1;
          r_rd_data <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_round_key_bank.sv
module tb_round_key_bank;

  localparam logic [127:0] K1 = 128'h8899aabbccddeeff0011223344556677;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         wr_start = 1'b0;
  logic         wr_bank = 1'b0;
  logic         wr_valid = 1'b0;
  logic [127:0] wr_data = '0;
  logic         wr_ready;
  logic         zeroize = 1'b0;
  logic         rd_en = 1'b0;
  logic         rd_bank = 1'b0;
  logic [3:0]   rd_addr = '0;
  logic [127:0] rd_data;
  logic         rd_valid;
  logic         rd_err;
  logic [1:0]   bank_ready;
  logic         busy;

  typedef struct {
    logic [127:0] data;
    logic         err;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  round_key_bank dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_wr_start   (wr_start),
    .i_wr_bank    (wr_bank),
    .i_wr_valid   (wr_valid),
    .i_wr_data    (wr_data),
    .o_wr_ready   (wr_ready),
    .i_zeroize    (zeroize),
    .i_rd_en      (rd_en),
    .i_rd_bank    (rd_bank),
    .i_rd_addr    (rd_addr),
    .o_rd_data    (rd_data),
    .o_rd_valid   (rd_valid),
    .o_rd_err     (rd_err),
    .o_bank_ready (bank_ready),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  // Key sets: set 0 starts with the reference K1.
  function automatic logic [127:0] key(input int s, input int i);
    logic [127:0] base;
    case (s)
      0:       base = K1;
      1:       base = 128'h0123456789abcdeffedcba9876543210;
      default: base = 128'hdeadbeefcafef00d5a5a5a5aa5a5a5a5;
    endcase
    return base ^ {16{8'(i + 1)}} ^ {16{8'h01}};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic b, input logic [3:0] a, input logic [127:0] d, input logic e);
    exp_t x;
    x.data  = d;
    x.err   = e;
    rd_en   = 1'b1;
    rd_bank = b;
    rd_addr = a;
    exp_q.push_back(x);
    tick();
    rd_en = 1'b0;
  endtask

  // Full load; in toggle mode wr_valid idles every other cycle, those idle cycles read the
  // other bank (which must hold set 0) and one of them carries an ignored wr_start.
  task automatic load(input logic b, input int s, input bit toggle);
    wr_start = 1'b1;
    wr_bank  = b;
    tick();
    wr_start = 1'b0;
    check("wr_ready_in_load", 128'(wr_ready), 128'(1));
    for (int i = 0; i < 10; i++) begin
      wr_valid = 1'b1;
      wr_data  = key(s, i);
      tick();
      wr_valid = 1'b0;
      if (toggle) begin
        if (i == 4) begin
          wr_start = 1'b1;
          wr_bank  = ~b;
        end
        rd(~b, 4'(i), key(0, i), 1'b0);
        wr_start = 1'b0;
      end
    end
  endtask

  task automatic count_zero(input string name);
    int cnt = 0;
    while (busy && cnt < 100) begin
      tick();
      cnt++;
    end
    check(name, 128'(cnt), 128'(20));
  endtask

  // Scoreboard monitor: every read response is matched against the queued expectation.
  always @(negedge clk) begin
    if (rd_valid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got data %h err %b expected no response", rd_data, rd_err);
      end else begin
        exp_t x;
        x = exp_q.pop_front();
        if (rd_data !== x.data || rd_err !== x.err) begin
          errors++;
          $display("FAIL rd_resp: got data %h err %b expected data %h err %b",
                   rd_data, rd_err, x.data, x.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values
    tick();
    check("rst_wr_ready", 128'(wr_ready), 128'(0));
    check("rst_rd_valid", 128'(rd_valid), 128'(0));
    check("rst_rd_err", 128'(rd_err), 128'(0));
    check("rst_rd_data", rd_data, 128'(0));
    check("rst_bank_ready", 128'(bank_ready), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    rst = 1'b0;
    tick();

    // 1: load bank0, read back-to-back, then data hold
    load(1'b0, 0, 1'b0);
    check("t1_bank_ready", 128'(bank_ready), 128'(2'b01));
    check("t1_busy", 128'(busy), 128'(0));
    for (int i = 0; i < 10; i++) rd(1'b0, 4'(i), key(0, i), 1'b0);
    tick();
    check("t1_rd_valid_idle", 128'(rd_valid), 128'(0));
    check("t1_rd_data_hold", rd_data, key(0, 9));

    // 2: unloaded bank
    rd(1'b1, 4'd0, 128'(0), 1'b1);

    // 3: throttled load of bank1 while bank0 stays readable
    load(1'b1, 1, 1'b1);
    check("t3_bank_ready", 128'(bank_ready), 128'(2'b11));
    for (int i = 0; i < 10; i++) rd(1'b1, 4'(i), key(1, i), 1'b0);
    rd(1'b1, 4'd10, 128'(0), 1'b1);
    rd(1'b0, 4'd15, 128'(0), 1'b1);
    rd(1'b0, 4'd0, key(0, 0), 1'b0);

    // 4: zeroize from IDLE, then reload bank0 only
    zeroize = 1'b1;
    tick();
    zeroize = 1'b0;
    check("t4_bank_ready", 128'(bank_ready), 128'(0));
    check("t4_busy", 128'(busy), 128'(1));
    count_zero("t4_zero_cycles");
    load(1'b0, 2, 1'b0);
    rd(1'b1, 4'd5, 128'(0), 1'b1);
    rd(1'b0, 4'd5, key(2, 5), 1'b0);

    // 5: zeroize collides with a beat at ptr=4
    wr_start = 1'b1;
    wr_bank  = 1'b1;
    tick();
    wr_start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1;
      wr_data  = key(0, i);
      tick();
    end
    wr_data = key(0, 4);
    zeroize = 1'b1;
    tick();
    zeroize  = 1'b0;
    wr_valid = 1'b0;
    check("t5_wr_ready", 128'(wr_ready), 128'(0));
    check("t5_busy", 128'(busy), 128'(1));
    check("t5_bank_ready", 128'(bank_ready), 128'(0));
    count_zero("t5_zero_cycles");

    // 6: async reset mid-load at ptr=6
    load(1'b1, 1, 1'b0);
    check("t6_bank_ready_pre", 128'(bank_ready), 128'(2'b10));
    wr_start = 1'b1;
    wr_bank  = 1'b0;
    tick();
    wr_start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_valid = 1'b1;
      wr_data  = key(0, i);
      if (i == 5) begin
        rd_en   = 1'b1;
        rd_bank = 1'b1;
        rd_addr = 4'd2;
      end
      tick();
    end
    wr_valid = 1'b0;
    rd_en    = 1'b0;
    check("t6_pre_rst_rd_valid", 128'(rd_valid), 128'(1));
    check("t6_pre_rst_rd_data", rd_data, key(1, 2));
    #2 rst = 1'b1;
    #1;
    check("t6_rst_busy", 128'(busy), 128'(0));
    check("t6_rst_wr_ready", 128'(wr_ready), 128'(0));
    check("t6_rst_bank_ready", 128'(bank_ready), 128'(0));
    check("t6_rst_rd_valid", 128'(rd_valid), 128'(0));
    check("t6_rst_rd_data", rd_data, 128'(0));
    tick();
    rst = 1'b0;
    tick();
    load(1'b0, 2, 1'b0);
    check("t6_bank_ready_post", 128'(bank_ready), 128'(2'b01));
    rd(1'b0, 4'd0, key(2, 0), 1'b0);
    rd(1'b0, 4'd9, key(2, 9), 1'b0);
    rd(1'b1, 4'd0, 128'(0), 1'b1);

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) tick();
    check("scoreboard_drain", 128'(exp_q.size()), 128'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
